// File: rtl/calram_lab_feeder_if.sv
// Sample-side and calram-side bus of the LAB4 calram feeder.
// master = sample source / calram sink view, slave = feeder view.
interface calram_lab_feeder_if #(
    parameter int LAB4_BITS   = 12,
    parameter int NUM_WINDOWS = 32
);
    localparam int WIN_W = $clog2(NUM_WINDOWS);

    logic [LAB4_BITS-1:0] sample_dat;
    logic                 sample_valid;
    logic                 window_start;
    logic [WIN_W-1:0]     window_addr;

    logic [LAB4_BITS-1:0] lab_dat;
    logic                 lab_wr;
    logic                 roll_done;

    modport master (
        output sample_dat, sample_valid, window_start, window_addr,
        input  lab_dat, lab_wr, roll_done
    );

    modport slave (
        input  sample_dat, sample_valid, window_start, window_addr,
        output lab_dat, lab_wr, roll_done
    );
endinterface

// File: rtl/calram_lab_feeder.sv
// Aligns a raw LAB4 sample stream to window 0 / sample 0 and forwards whole
// 4096-sample rolls into the calibration RAM, halting on any sequence break.
module calram_lab_feeder #(
    parameter int LAB4_BITS   = 12,
    parameter int WIN_SAMPLES = 128,
    parameter int NUM_WINDOWS = 32
) (
    input  logic sys_clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic resync_i,
    calram_lab_feeder_if.slave bus,
    output logic locked_o,
    output logic seq_err_o
);
    localparam int SAMP_W = $clog2(WIN_SAMPLES);
    localparam int WIN_W  = $clog2(NUM_WINDOWS);

    typedef enum logic [1:0] {IDLE, SEEK, PASS, HALT} state_t;

    state_t               state_q, state_d;
    logic [SAMP_W-1:0]    samp_q, samp_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [LAB4_BITS-1:0] dat_q, dat_d;
    logic                 wr_q, wr_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic last_samp, last_win, seq_bad;

    assign last_samp = (samp_q == SAMP_W'(WIN_SAMPLES - 1));
    assign last_win  = (win_q == WIN_W'(NUM_WINDOWS - 1));

    // A window start must land exactly on sample 0 of the expected window,
    // and sample 0 must always carry a window start.
    assign seq_bad = (bus.window_start && (samp_q != '0))
                  || (!bus.window_start && (samp_q == '0))
                  || (bus.window_start && (bus.window_addr != win_q));

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        samp_d  = samp_q;
        win_d   = win_q;
        dat_d   = dat_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;

        if (resync_i) begin
            err_d   = 1'b0;
            samp_d  = '0;
            win_d   = '0;
            state_d = en_i ? SEEK : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i) state_d = SEEK;
                end
                SEEK: begin
                    if (!en_i) begin
                        state_d = IDLE;
                    end else if (bus.sample_valid && bus.window_start &&
                                 (bus.window_addr == '0)) begin
                        dat_d   = bus.sample_dat;
                        wr_d    = 1'b1;
                        samp_d  = SAMP_W'(1);
                        win_d   = '0;
                        state_d = PASS;
                    end
                end
                PASS: begin
                    if (bus.sample_valid) begin
                        if (seq_bad) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            dat_d  = bus.sample_dat;
                            wr_d   = 1'b1;
                            samp_d = samp_q + SAMP_W'(1);
                            if (last_samp) win_d = win_q + WIN_W'(1);
                            if (last_samp && last_win) begin
                                done_d = 1'b1;
                                // A stop request is honoured only here, so
                                // calram never sees a partial roll.
                                if (!en_i) state_d = IDLE;
                            end
                        end
                    end
                end
                HALT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            samp_q  <= '0;
            win_q   <= '0;
            dat_q   <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            samp_q  <= samp_d;
            win_q   <= win_d;
            dat_q   <= dat_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.lab_dat   = dat_q;
    assign bus.lab_wr    = wr_q;
    assign bus.roll_done = done_q;
    assign locked_o      = (state_q == PASS);
    assign seq_err_o     = err_q;
endmodule
